// File: rtl/booth_mul_sched.sv
// booth_mul_sched: two-way round-robin arbiter feeding a shared radix-2 Booth multiplier, one bit per clock
module booth_mul_sched #(
    parameter int WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid0,
    input  logic [WIDTH-1:0]       a0,
    input  logic [WIDTH-1:0]       b0,
    output logic                   ready0,
    input  logic                   valid1,
    input  logic [WIDTH-1:0]       a1,
    input  logic [WIDTH-1:0]       b1,
    output logic                   ready1,
    output logic                   res_valid,
    output logic                   res_id,
    output logic [2*WIDTH-1:0]     product,
    output logic                   busy
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             r_state;
    logic               r_ptr;
    logic               r_owner;
    logic               r_e;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2*WIDTH:0]   r_acc;

    logic               w_idle;
    logic               w_bit;
    logic [WIDTH:0]     w_bx;
    logic [WIDTH:0]     w_up;
    logic [2*WIDTH:0]   w_sum;

    assign w_idle = (r_state == IDLE) && !rst;
    assign ready0 = w_idle && valid0 && (!valid1 || !r_ptr);
    assign ready1 = w_idle && valid1 && (!valid0 || r_ptr);
    assign busy   = (r_state != IDLE);

    // upper half is one bit wider than b so that -b stays exact for the most negative b
    assign w_bit = r_a[r_cnt];
    assign w_bx  = {r_b[WIDTH-1], r_b};
    assign w_up  = r_acc[2*WIDTH:WIDTH] + (({w_bit, r_e} == 2'b10) ? -w_bx :
                                           ({w_bit, r_e} == 2'b01) ?  w_bx : '0);
    assign w_sum = {w_up, r_acc[WIDTH-1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_ptr     <= 1'b0;
            res_valid <= 1'b0;
            res_id    <= 1'b0;
            product   <= '0;
        end else begin
            res_valid <= 1'b0;
            case (r_state)
                IDLE: if (ready0 || ready1) begin
                    r_a     <= ready1 ? a1 : a0;
                    r_b     <= ready1 ? b1 : b0;
                    r_owner <= ready1;
                    r_ptr   <= !ready1;
                    r_acc   <= '0;
                    r_e     <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= RUN;
                end
                RUN: begin
                    r_acc   <= {w_sum[2*WIDTH], w_sum[2*WIDTH:1]};
                    r_e     <= w_bit;
                    r_cnt   <= r_cnt + 1'b1;
                    r_state <= (r_cnt == LAST) ? DONE : RUN;
                end
                DONE: begin
                    product   <= r_acc[2*WIDTH-1:0];
                    res_id    <= r_owner;
                    res_valid <= 1'b1;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_booth_mul_sched.sv
// tb_booth_mul_sched: directed and exhaustive checks of the Booth multiply scheduler against a result queue
module tb_booth_mul_sched;
    logic       clk;
    logic       rst;
    logic       valid0, valid1;
    logic [3:0] a0, b0, a1, b1;
    logic       ready0, ready1;
    logic       res_valid, res_id, busy;
    logic [7:0] product;

    int n_chk = 0;
    int n_fail = 0;
    logic [8:0] sb[$];
    logic signed [7:0] w_p0, w_p1;

    assign w_p0 = $signed(a0) * $signed(b0);
    assign w_p1 = $signed(a1) * $signed(b1);

    booth_mul_sched #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .valid0(valid0), .a0(a0), .b0(b0), .ready0(ready0),
        .valid1(valid1), .a1(a1), .b1(b1), .ready1(ready1),
        .res_valid(res_valid), .res_id(res_id), .product(product), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (valid0 && ready0) sb.push_back({1'b0, w_p0});
            if (valid1 && ready1) sb.push_back({1'b1, w_p1});
            chk("ready_onehot", {31'd0, ready0 & ready1}, 0);
            if (busy) chk("ready_while_busy", {30'd0, ready0, ready1}, 0);
            if (res_valid) begin
                if (sb.size() == 0) chk("unexpected_res_valid", {31'd0, res_valid}, 0);
                else begin
                    logic [8:0] e;
                    e = sb.pop_front();
                    chk("product", {24'd0, product}, {24'd0, e[7:0]});
                    chk("res_id", {31'd0, res_id}, {31'd0, e[8]});
                end
            end
        end
    end

    task automatic send(input bit k, input logic [3:0] a, input logic [3:0] b);
        int n;
        @(posedge clk); #1;
        if (k) begin valid1 = 1'b1; a1 = a; b1 = b; end
        else   begin valid0 = 1'b1; a0 = a; b0 = b; end
        n = 0;
        @(negedge clk);
        while (!(k ? ready1 : ready0) && n < 40) begin n++; @(negedge clk); end
        chk("accept_timeout", {31'd0, n < 40}, 1);
        @(posedge clk); #1;
        if (k) valid1 = 1'b0; else valid0 = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < 60) begin n++; @(negedge clk); end
        chk("drain_timeout", sb.size(), 0);
    endtask

    initial begin
        int busy_cnt, rv_cnt, rv_at, n;
        logic [3:0] fa0[3], fb0[3], fa1[2], fb1[2];
        int i0, i1;
        bit got;
        fa0 = '{4'd2, 4'hC, 4'd6}; fb0 = '{4'd3, 4'd5, 4'h9};
        fa1 = '{4'hF, 4'd7};       fb1 = '{4'hF, 4'd7};
        rst = 1'b1; valid1 = 1'b1; a1 = 4'd1; b1 = 4'd1;
        valid0 = 1'b1; a0 = 4'd3; b0 = 4'hE;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready0", {31'd0, ready0}, 0);
        chk("rst_ready1", {31'd0, ready1}, 0);
        chk("rst_res_valid", {31'd0, res_valid}, 0);
        chk("rst_res_id", {31'd0, res_id}, 0);
        chk("rst_product", {24'd0, product}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        @(posedge clk); #1;
        rst = 1'b0; valid1 = 1'b0;
        @(negedge clk);
        chk("first_ready0", {31'd0, ready0}, 1);
        @(posedge clk); #1;
        valid0 = 1'b0;
        busy_cnt = 0; rv_cnt = 0; rv_at = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (res_valid) begin
                rv_cnt++; rv_at = i;
                chk("lat_product", {24'd0, product}, 32'hFA);
                chk("lat_res_id", {31'd0, res_id}, 0);
            end
        end
        chk("busy_cycles", busy_cnt, 5);
        chk("res_valid_at", rv_at, 6);
        chk("res_valid_count", rv_cnt, 1);
        chk("product_hold", {24'd0, product}, 32'hFA);

        send(1'b1, 4'h8, 4'h8);
        drain();
        chk("neg8_sq", {24'd0, product}, 32'h40);
        send(1'b0, 4'd7, 4'h8);
        drain();
        chk("7_x_neg8", {24'd0, product}, 32'hC8);
        send(1'b0, 4'h8, 4'd7);
        drain();
        chk("neg8_x_7", {24'd0, product}, 32'hC8);
        send(1'b0, 4'd0, 4'h8);
        drain();
        chk("0_x_neg8", {24'd0, product}, 32'h00);

        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        i0 = 0; i1 = 0;
        valid0 = 1'b1; a0 = fa0[0]; b0 = fb0[0];
        valid1 = 1'b1; a1 = fa1[0]; b1 = fb1[0];
        for (int g = 0; g < 5; g++) begin
            n = 0;
            @(negedge clk);
            while (!(ready0 || ready1) && n < 40) begin n++; @(negedge clk); end
            chk("grant_order", {31'd0, ready1}, g % 2);
            got = ready1;
            @(posedge clk); #1;
            if (got) begin
                i1++;
                if (i1 < 2) begin a1 = fa1[i1]; b1 = fb1[i1]; end else valid1 = 1'b0;
            end else begin
                i0++;
                if (i0 < 3) begin a0 = fa0[i0]; b0 = fb0[i0]; end else valid0 = 1'b0;
            end
        end
        drain();
        chk("fair_last", {24'd0, product}, 32'hD6);

        send(1'b0, 4'd5, 4'd3);
        @(posedge clk); #1 rst = 1'b1;
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        chk("abort_product", {24'd0, product}, 0);
        chk("abort_res_valid", {31'd0, res_valid}, 0);
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_res_id", {31'd0, res_id}, 0);
        @(posedge clk); #1 rst = 1'b0;
        rv_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (res_valid) rv_cnt++;
        end
        chk("abort_no_strobe", rv_cnt, 0);
        send(1'b1, 4'hD, 4'd5);
        drain();
        chk("post_abort", {24'd0, product}, 32'hF1);

        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                send(1'($urandom_range(0, 1)), 4'(ai), 4'(bi));
            end
        end
        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/booth_mul_sched.md
Name: booth_mul_sched

Overview:
- Sequencing controller and two-way arbiter for a shared iterative radix-2 Booth multiply engine.
- Two requesters present signed operand pairs over valid/ready handshakes.
- The block grants one requester round-robin, runs the Booth recoding one bit per clock, and returns the signed product with the requester ID.
- Sits between the requester datapaths and the arithmetic core, replacing per-requester combinational multipliers.

Parameters:
WIDTH, 4, operand width in bits (signed two's complement); product is 2*WIDTH bits; legal range 2..16.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
valid0  input  1  requester 0 has an operand pair
a0  input  WIDTH  requester 0 multiplier (bits scanned), signed
b0  input  WIDTH  requester 0 multiplicand, signed
ready0  output  1  requester 0 accepted this cycle
valid1  input  1  requester 1 has an operand pair
a1  input  WIDTH  requester 1 multiplier, signed
b1  input  WIDTH  requester 1 multiplicand, signed
ready1  output  1  requester 1 accepted this cycle
res_valid  output  1  one-cycle result strobe
res_id  output  1  requester that owns the result
product  output  2*WIDTH  signed product a*b
busy  output  1  engine occupied (RUN or DONE)

Behaviour:
- Reset: synchronous. On rst=1 at a clock edge the FSM goes to IDLE, the iteration counter clears and the round-robin pointer is set to 0 (requester 0 favoured).
- Registered outputs after reset: res_valid=0, res_id=0, product=0, busy=0.
- ready0 and ready1 are 0 while rst=1.
- A reset during RUN or DONE aborts the operation. No res_valid is emitted for it.
- FSM states: IDLE, RUN, DONE.
- IDLE, grant logic: ready0 and ready1 are combinational and at most one is high.
  - Only one valid high: that requester gets ready.
  - Both valid high: the requester equal to the pointer gets ready.
- IDLE, handshake: a transfer occurs when validk and readyk are both high at the edge. On transfer the block:
  - captures ak and bk into internal registers;
  - records k as the owner;
  - sets the pointer to the other requester (1-k);
  - clears the accumulator and the Booth extra bit e;
  - sets counter=0 and goes to RUN.
- IDLE with no valid: stay in IDLE.
- RUN ready levels: ready0=ready1=0 in RUN and DONE. New requests wait with valid held high.
- Requester rule: a requester must keep valid and its operands stable until its ready is seen; the checker flags any violation.
- RUN, one iteration per clock, i = counter (0..WIDTH-1):
  - {a[i], e}=10: upper half of the accumulator += -b.
  - {a[i], e}=01: upper half += b.
  - 00 or 11: no change.
  - Then arithmetic shift right by 1, set e=a[i], counter++.
  - After the iteration with counter=WIDTH-1, go to DONE.
- Accumulator width: 2*WIDTH+1 bits; the upper part is WIDTH+1 bits. This makes -b exact for b = -2^(WIDTH-1) and keeps the result correct for all operand pairs, including (-2^(WIDTH-1))^2.
- DONE, single cycle:
  - product = accumulator bits [2*WIDTH-1:0];
  - res_id = owner; res_valid=1; then go to IDLE.
  - res_valid is high in exactly one cycle. There is no result back-pressure; consumers must sample the strobe.
- Latency: handshake at edge T → RUN occupies edges T+1..T+WIDTH → res_valid is high in the cycle after edge T+WIDTH+1. Total is WIDTH+2 cycles from accept to strobe.
- Throughput: one accept per WIDTH+2 cycles. The next accept can occur in the cycle after the DONE cycle.
- product and res_id hold their values after res_valid drops, until the next DONE.
- busy = 1 in RUN and DONE, 0 in IDLE.
- Fairness: while both valid inputs stay high, grants alternate 0,1,0,1…

Test Plan:
- WIDTH=4. Reset, then valid0 with a0=3, b0=-2 → ready0 for one cycle; res_valid exactly 6 cycles after the accept edge; product=8'hFA (-6), res_id=0; busy high for 5 cycles.
- Corner operands: a1=-8, b1=-8 → product=8'h40 (+64). a0=7, b0=-8 → 8'hC8 (-56). a0=-8, b0=7 → 8'hC8. a0=0, b0=-8 → 8'h00.
- valid0 and valid1 both held high from reset → grant order 0,1,0,1. Each product matches its own operands and res_id alternates 0,1,0,1.
- rst asserted on the 2nd RUN cycle → outputs return to zero on the next edge and no res_valid is ever emitted for the aborted op. A request issued after reset completes with a correct product.
- Exhaustive random pass over all 256 (a,b) pairs with random valid gaps → every product equals a*b sign-extended to 8 bits, and no ready is seen while busy=1.
